// File: rtl/slc3_rf_pkg.sv
// Shared constants and address-width helper for the SLC-3 multi-port register file.
package slc3_rf_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 8;
    localparam int RF_NUM_RD   = 2;

    function automatic int rf_aw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [rf_aw(RF_NUM_REGS)-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Datapath-side bundle of the register file: two write ports, load issue, packed read ports, scoreboard view.
interface reg_file_mp_if
    import slc3_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD,
    localparam int AW      = rf_aw(NUM_REGS)
);

    logic                     wa_en;
    logic [AW-1:0]            wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [AW-1:0]            wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_rdy;
    logic [NUM_REGS-1:0]      busy;
    logic                     any_busy;

    modport master (
        output wa_en, wa_addr, wa_data,
        output wb_en, wb_addr, wb_data,
        output iss_en, iss_addr,
        output rd_addr,
        input  rd_data, rd_rdy, busy, any_busy
    );

    modport slave (
        input  wa_en, wa_addr, wa_data,
        input  wb_en, wb_addr, wb_data,
        input  iss_en, iss_addr,
        input  rd_addr,
        output rd_data, rd_rdy, busy, any_busy
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register load-in-flight bits; a same-cycle issue beats the writeback since it is the newer load.
module rf_scoreboard
    import slc3_rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    localparam int AW      = rf_aw(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                any_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (iss_en && iss_addr == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (wb_en && wb_addr == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports (load return wins), zero-latency bypassed reads, load scoreboard.
module reg_file_mp
    import slc3_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_R0  = 0,
    localparam int AW      = rf_aw(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  rf
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wa_ok;
    logic                wb_ok;
    logic                iss_ok;

    // With a hardwired R0, anything aimed at address 0 is simply dropped here.
    always_comb begin
        wa_ok  = rf.wa_en  && !(ZERO_R0 != 0 && rf.wa_addr  == '0);
        wb_ok  = rf.wb_en  && !(ZERO_R0 != 0 && rf.wb_addr  == '0);
        iss_ok = rf.iss_en && !(ZERO_R0 != 0 && rf.iss_addr == '0);
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wa_ok) begin
            regs_d[rf.wa_addr] = rf.wa_data;
        end
        if (wb_ok) begin
            regs_d[rf.wb_addr] = rf.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reset) begin
                regs_q[r] <= '0;
            end else begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_ok),
        .iss_addr (rf.iss_addr),
        .wb_en    (wb_ok),
        .wb_addr  (rf.wb_addr),
        .busy     (busy),
        .any_busy (rf.any_busy)
    );

    assign rf.busy = busy;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rd_dat;
        logic              rd_ok;

        assign ra = rf.rd_addr[i*AW +: AW];

        always_comb begin
            rd_dat = regs_q[ra];
            rd_ok  = !busy[ra];
            if (ZERO_R0 != 0 && ra == '0) begin
                rd_dat = '0;
                rd_ok  = 1'b1;
            end else if (rf.wb_en && rf.wb_addr == ra) begin
                rd_dat = rf.wb_data;
                rd_ok  = 1'b1;
            end else if (rf.wa_en && rf.wa_addr == ra) begin
                rd_dat = rf.wa_data;
            end
        end

        assign rf.rd_data[i*DATA_W +: DATA_W] = rd_dat;
        assign rf.rd_rdy[i]                   = rd_ok;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed vectors plus randomized traffic against a behavioural model, on a default and a ZERO_R0/3-port instance.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) bus0 ();
    reg_file_mp_if #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3)) bus1 ();

    reg_file_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .ZERO_R0(0)) dut0 (
        .clk(clk), .reset(reset), .rf(bus0));
    reg_file_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .ZERO_R0(1)) dut1 (
        .clk(clk), .reset(reset), .rf(bus1));

    assign bus1.wa_en    = bus0.wa_en;
    assign bus1.wa_addr  = bus0.wa_addr;
    assign bus1.wa_data  = bus0.wa_data;
    assign bus1.wb_en    = bus0.wb_en;
    assign bus1.wb_addr  = bus0.wb_addr;
    assign bus1.wb_data  = bus0.wb_data;
    assign bus1.iss_en   = bus0.iss_en;
    assign bus1.iss_addr = bus0.iss_addr;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: index 0 = plain file, index 1 = file with hardwired R0.
    logic [15:0] m_regs [2][8];
    logic [7:0]  m_busy [2];

    typedef struct {
        logic        rst;
        logic        wa_en;  logic [2:0] wa_a;  logic [15:0] wa_d;
        logic        wb_en;  logic [2:0] wb_a;  logic [15:0] wb_d;
        logic        iss_en; logic [2:0] iss_a;
        logic [2:0]  r0;     logic [2:0] r1;
        logic [15:0] e0;     logic [15:0] e1;
        logic [1:0]  erdy;   logic [7:0] ebusy;
    } vec_t;

    vec_t vt [0:16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic drive(input logic rst, input logic wae, input logic [2:0] waa, input logic [15:0] wad,
                         input logic wbe, input logic [2:0] wba, input logic [15:0] wbd,
                         input logic ise, input logic [2:0] isa);
        reset         = rst;
        bus0.wa_en    = wae; bus0.wa_addr  = waa; bus0.wa_data = wad;
        bus0.wb_en    = wbe; bus0.wb_addr  = wba; bus0.wb_data = wbd;
        bus0.iss_en   = ise; bus0.iss_addr = isa;
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 8; r++) m_regs[k][r] = 16'h0;
                m_busy[k] = 8'h00;
            end else begin
                if (bus0.wa_en && !(k == 1 && bus0.wa_addr == 3'd0)) m_regs[k][bus0.wa_addr] = bus0.wa_data;
                if (bus0.wb_en && !(k == 1 && bus0.wb_addr == 3'd0)) begin
                    m_regs[k][bus0.wb_addr] = bus0.wb_data;
                    m_busy[k][bus0.wb_addr] = 1'b0;
                end
                if (bus0.iss_en && !(k == 1 && bus0.iss_addr == 3'd0)) m_busy[k][bus0.iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [16:0] exp_rd(input int k, input logic [2:0] a);
        logic        wb_hit;
        logic [15:0] d;
        if (k == 1 && a == 3'd0) return {1'b1, 16'h0000};
        wb_hit = bus0.wb_en && bus0.wb_addr == a;
        if (wb_hit) d = bus0.wb_data;
        else if (bus0.wa_en && bus0.wa_addr == a) d = bus0.wa_data;
        else d = m_regs[k][a];
        return {(!m_busy[k][a]) || wb_hit, d};
    endfunction

    task automatic check_model();
        logic [16:0] e;
        for (int p = 0; p < 2; p++) begin
            e = exp_rd(0, bus0.rd_addr[p*3 +: 3]);
            check($sformatf("rnd0 data p%0d", p), {16'h0, bus0.rd_data[p*16 +: 16]}, {16'h0, e[15:0]});
            check($sformatf("rnd0 rdy p%0d", p), {31'h0, bus0.rd_rdy[p]}, {31'h0, e[16]});
        end
        for (int p = 0; p < 3; p++) begin
            e = exp_rd(1, bus1.rd_addr[p*3 +: 3]);
            check($sformatf("rnd1 data p%0d", p), {16'h0, bus1.rd_data[p*16 +: 16]}, {16'h0, e[15:0]});
            check($sformatf("rnd1 rdy p%0d", p), {31'h0, bus1.rd_rdy[p]}, {31'h0, e[16]});
        end
        check("rnd0 busy", {24'h0, bus0.busy}, {24'h0, m_busy[0]});
        check("rnd1 busy", {24'h0, bus1.busy}, {24'h0, m_busy[1]});
        check("rnd0 any_busy", {31'h0, bus0.any_busy}, {31'h0, |m_busy[0]});
        check("rnd1 any_busy", {31'h0, bus1.any_busy}, {31'h0, |m_busy[1]});
    endtask

    initial begin
        //          rst wa        wb               iss     r0 r1  e0        e1        rdy    busy
        vt[0]  = '{0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,7, 16'h0000, 16'h0000, 2'b11, 8'h00};
        vt[1]  = '{0, 1,3,16'h1234, 0,0,16'h0,    0,0, 3,4, 16'h1234, 16'h0000, 2'b11, 8'h00};
        vt[2]  = '{0, 0,0,16'h0,    0,0,16'h0,    0,0, 3,3, 16'h1234, 16'h1234, 2'b11, 8'h00};
        vt[3]  = '{0, 1,5,16'hAAAA, 1,5,16'h5555, 0,0, 5,3, 16'h5555, 16'h1234, 2'b11, 8'h00};
        vt[4]  = '{0, 0,0,16'h0,    0,0,16'h0,    0,0, 5,5, 16'h5555, 16'h5555, 2'b11, 8'h00};
        vt[5]  = '{0, 0,0,16'h0,    0,0,16'h0,    1,2, 2,5, 16'h0000, 16'h5555, 2'b11, 8'h00};
        vt[6]  = '{0, 0,0,16'h0,    0,0,16'h0,    0,0, 2,5, 16'h0000, 16'h5555, 2'b10, 8'h04};
        vt[7]  = '{0, 1,2,16'h1111, 0,0,16'h0,    0,0, 2,2, 16'h1111, 16'h1111, 2'b00, 8'h04};
        vt[8]  = '{0, 0,0,16'h0,    0,0,16'h0,    0,0, 2,2, 16'h1111, 16'h1111, 2'b00, 8'h04};
        vt[9]  = '{0, 0,0,16'h0,    1,2,16'hBEEF, 0,0, 2,2, 16'hBEEF, 16'hBEEF, 2'b11, 8'h04};
        vt[10] = '{0, 0,0,16'h0,    0,0,16'h0,    0,0, 2,2, 16'hBEEF, 16'hBEEF, 2'b11, 8'h00};
        vt[11] = '{0, 0,0,16'h0,    1,6,16'h0F0F, 1,6, 6,0, 16'h0F0F, 16'h0000, 2'b11, 8'h00};
        vt[12] = '{0, 0,0,16'h0,    0,0,16'h0,    0,0, 6,6, 16'h0F0F, 16'h0F0F, 2'b00, 8'h40};
        vt[13] = '{0, 0,0,16'h0,    1,6,16'h2222, 0,0, 6,1, 16'h2222, 16'h0000, 2'b11, 8'h40};
        vt[14] = '{0, 0,0,16'h0,    0,0,16'h0,    1,1, 1,1, 16'h0000, 16'h0000, 2'b11, 8'h00};
        vt[15] = '{1, 0,0,16'h0,    1,1,16'h7777, 0,0, 1,6, 16'h7777, 16'h2222, 2'b11, 8'h02};
        vt[16] = '{0, 0,0,16'h0,    0,0,16'h0,    0,0, 1,6, 16'h0000, 16'h0000, 2'b11, 8'h00};

        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) m_regs[k][r] = 16'h0;
            m_busy[k] = 8'h00;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        bus0.rd_addr = '0;
        bus1.rd_addr = '0;
        #4;
        tick();

        for (int i = 0; i <= 16; i++) begin
            drive(vt[i].rst, vt[i].wa_en, vt[i].wa_a, vt[i].wa_d, vt[i].wb_en, vt[i].wb_a, vt[i].wb_d,
                  vt[i].iss_en, vt[i].iss_a);
            bus0.rd_addr = {vt[i].r1, vt[i].r0};
            #4;
            check($sformatf("vec%0d rd0", i), {16'h0, bus0.rd_data[15:0]}, {16'h0, vt[i].e0});
            check($sformatf("vec%0d rd1", i), {16'h0, bus0.rd_data[31:16]}, {16'h0, vt[i].e1});
            check($sformatf("vec%0d rdy", i), {30'h0, bus0.rd_rdy}, {30'h0, vt[i].erdy});
            check($sformatf("vec%0d busy", i), {24'h0, bus0.busy}, {24'h0, vt[i].ebusy});
            check($sformatf("vec%0d any_busy", i), {31'h0, bus0.any_busy}, {31'h0, |vt[i].ebusy});
            tick();
        end

        // Hardwired R0: write and issue to address 0 must leave no trace on dut1.
        drive(0, 1, 0, 16'hFFFF, 0, 0, 0, 1, 0);
        bus0.rd_addr = {3'd0, 3'd0};
        bus1.rd_addr = {3'd0, 3'd0, 3'd0};
        #4;
        check("z0 bypass data", {8'h0, bus1.rd_data}, 32'h0);
        check("z0 bypass rdy", {29'h0, bus1.rd_rdy}, 32'h7);
        check("r0 bypass dut0", {16'h0, bus0.rd_data[15:0]}, 32'hFFFF);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        check("z0 stored data", {8'h0, bus1.rd_data}, 32'h0);
        check("z0 stored rdy", {29'h0, bus1.rd_rdy}, 32'h7);
        check("z0 busy", {24'h0, bus1.busy}, 32'h0);
        check("r0 stored dut0", {16'h0, bus0.rd_data[15:0]}, 32'hFFFF);
        check("r0 busy dut0", {24'h0, bus0.busy}, 32'h1);
        tick();

        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
            bus0.rd_addr = 6'($urandom);
            bus1.rd_addr = 9'($urandom);
            #4;
            check_model();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
